// File: rtl/id_stage_buffer.sv
// id_stage_buffer: IF->ID stage built as a valid/ready circular buffer.
// The head entry is decoded combinationally. After a fence is popped, the
// stage blocks for FENCE_DRAIN cycles.
// Optional feature macro: ID_STAGE_RVM_EN adds MUL/DIV legality and the
// out_is_muldiv output.
module id_stage_buffer #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 2,
  parameter int FENCE_DRAIN = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_csr_inst,
  output logic            out_is_load,
  output logic            out_is_store,
  output logic            out_is_fence,
  output logic            out_ecall,
  output logic            out_illegal,
`ifdef ID_STAGE_RVM_EN
  output logic            out_is_muldiv,
`endif
  output logic            fence_busy
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int DW   = (FENCE_DRAIN > 0) ? $clog2(FENCE_DRAIN + 1) : 1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   drain_cnt_reg, drain_cnt_next;
  logic [CNTW-1:0] count_reg, count_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;

  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic            push, pop;
  logic [XLEN-1:0] head_inst, head_pc;
  logic [31:0]     d;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            legal, is_system;

  assign in_ready   = (count_reg < DEPTH_C) && (state_reg == RUN);
  assign out_valid  = (count_reg != '0) && (state_reg == RUN);
  assign fence_busy = (state_reg == DRAIN);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;

  assign head_inst = inst_mem[rd_ptr_reg];
  assign head_pc   = pc_mem[rd_ptr_reg];
  assign d         = head_inst[31:0];
  assign opcode    = d[6:0];
  assign f3        = d[14:12];
  assign f7        = d[31:25];
  assign is_system = (opcode == OPC_SYSTEM);

  // Buffer storage: write the tail entry on an accepted push (not during flush).
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      inst_mem[wr_ptr_reg] <= in_inst;
      pc_mem[wr_ptr_reg]   <= in_pc;
    end
  end

  // State register: occupancy, pointers, FSM state and drain counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= RUN;
      drain_cnt_reg <= '0;
      count_reg     <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      count_reg     <= count_next;
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
    end
  end

  // Next-state logic: flush wins; a popped fence opens the drain window.
  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    count_next     = count_reg;
    rd_ptr_next    = rd_ptr_reg;
    wr_ptr_next    = wr_ptr_reg;
    if (flush) begin
      state_next     = RUN;
      drain_cnt_next = '0;
      count_next     = '0;
      rd_ptr_next    = '0;
      wr_ptr_next    = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
      if (push && !pop)      count_next = count_reg + CNTW'(1);
      else if (pop && !push) count_next = count_reg - CNTW'(1);
      case (state_reg)
        RUN: begin
          if (pop && out_is_fence && (FENCE_DRAIN > 0)) begin
            state_next     = DRAIN;
            drain_cnt_next = DW'(FENCE_DRAIN);
          end
        end
        DRAIN: begin
          drain_cnt_next = drain_cnt_reg - DW'(1);
          if (drain_cnt_reg <= DW'(1)) begin
            state_next     = RUN;
            drain_cnt_next = '0;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // Legality check of the head instruction.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
      OPC_JALR:   legal = (f3 == 3'd0);
      OPC_BRANCH: legal = (f3 != 3'd2) && (f3 != 3'd3);
      OPC_LOAD:   legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                          (f3 == 3'd4) || (f3 == 3'd5);
      OPC_STORE:  legal = (f3 <= 3'd2);
      OPC_OPIMM: begin
        if (f3 == 3'd1)      legal = (f7 == 7'd0);
        else if (f3 == 3'd5) legal = (f7 == 7'd0) || (f7 == 7'b0100000);
        else                 legal = 1'b1;
      end
      OPC_OP: begin
        legal = (f7 == 7'd0) ||
                ((f7 == 7'b0100000) && ((f3 == 3'd0) || (f3 == 3'd5)));
`ifdef ID_STAGE_RVM_EN
        if (f7 == 7'b0000001) legal = 1'b1;
`endif
      end
      OPC_MISC:   legal = (f3 <= 3'd1);
      OPC_SYSTEM: legal = 1'b1;
      default:    legal = 1'b0;
    endcase
  end

  // Head outputs: decoded fields when valid, empty defaults otherwise.
  always_comb begin
    out_inst     = XLEN'(32'h0000_0013);
    out_pc       = '0;
    out_rs1      = '0;
    out_rs2      = '0;
    out_rd       = '0;
    out_csr_inst = '0;
    out_is_load  = 1'b0;
    out_is_store = 1'b0;
    out_is_fence = 1'b0;
    out_ecall    = 1'b0;
    out_illegal  = 1'b0;
`ifdef ID_STAGE_RVM_EN
    out_is_muldiv = 1'b0;
`endif
    if (out_valid) begin
      out_inst     = head_inst;
      out_pc       = head_pc;
      out_rs1      = d[19:15];
      out_rd       = d[11:7];
      out_rs2      = is_system ? 5'd0 : d[24:20];
      out_csr_inst = is_system ? head_inst : '0;
      out_is_load  = (opcode == OPC_LOAD);
      out_is_store = (opcode == OPC_STORE);
      out_is_fence = (opcode == OPC_MISC) ||
                     (is_system && (f7 == 7'b0001001) && (f3 == 3'd0));
      out_ecall    = (d == 32'h0000_0073);
      out_illegal  = !legal;
`ifdef ID_STAGE_RVM_EN
      out_is_muldiv = (opcode == OPC_OP) && (f7 == 7'b0000001);
`endif
    end
  end

endmodule

// File: doc/id_stage_buffer.md
# id_stage_buffer

Parametrised IF→ID pipeline stage that replaces the single fixed decode register with a valid/ready FIFO of configurable depth. It classifies the instruction at its head, extracts register fields, and enforces a configurable post-fence drain window. It sits between instruction fetch and the register-read/execute stage.

## Interface
- XLEN, 32, width of instruction and PC paths; instruction decode uses bits [31:0].
- DEPTH, 2, buffer entries; power of two, ≥2.
- FENCE_DRAIN, 8, cycles the stage stays blocked after a fence leaves; 0 disables the drain.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts; push = in_valid & in_ready.
- in_inst  in  XLEN  fetched instruction.
- in_pc  in  XLEN  its PC.
- flush  in  1  discard all entries and abort any drain.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts; pop = out_valid & out_ready.
- out_inst  out  XLEN  head instruction; 0x00000013 when empty.
- out_pc  out  XLEN  head PC; 0 when empty.
- out_rs1, out_rs2, out_rd  out  5 each  register fields; 0 when empty.
- out_csr_inst  out  XLEN  head instruction if opcode is SYSTEM (1110011), else 0.
- out_is_load, out_is_store, out_is_fence, out_ecall, out_illegal  out  1 each  head classification; all 0 when empty.
- fence_busy  out  1  drain window active.

## Operation
- Storage: circular buffer, rd/wr pointers wrap modulo DEPTH; count width $clog2(DEPTH+1).
- Push and pop in the same cycle: count unchanged, both pointers advance.
- No bypass: a pushed entry is visible at out_* only from the next cycle.
- in_ready = (count < DEPTH) & (state == RUN). It does not depend on out_ready. A full buffer with a pop in the same cycle still refuses the push.
- Field extraction from the head entry:
  - rs1 = inst[19:15] and rd = inst[11:7].
  - rs2 = 0 for SYSTEM, else inst[24:20].
- Legal set:
  - LUI and AUIPC.
  - JAL.
  - JALR with f3=0.
  - BRANCH with f3 ∉ {2,3}.
  - LOAD with f3 ∈ {0,1,2,4,5}.
  - STORE with f3 ∈ {0,1,2}.
  - OP-IMM: f3=1 requires f7=0; f3=5 requires f7 ∈ {0, 0100000}.
  - OP: f7=0, or f7=0100000 with f3 ∈ {0,5}.
  - MISC-MEM with f3 ∈ {0,1}.
  - SYSTEM.
  - Everything else sets out_illegal (when out_valid).
- out_is_fence = MISC-MEM, or SFENCE.VMA (f7=0001001, f3=0, SYSTEM).
- out_ecall = inst == 0x00000073.
- States:
  - RUN: normal.
  - DRAIN: out_valid=0, in_ready=0, fence_busy=1.
- RUN→DRAIN when a pop occurs with out_is_fence=1 and FENCE_DRAIN>0. The down-counter loads FENCE_DRAIN.
- In DRAIN the counter decrements each cycle. DRAIN→RUN on the cycle the counter goes 1→0.
- Flush (highest priority):
  - count←0 and pointers←0.
  - state←RUN and counter←0.
  - A push in the same cycle is dropped. A fence popped in the same cycle does not start a drain.
- Entries already buffered during DRAIN are held, not lost.

## Timing
- Reset values: count 0, state RUN, counter 0, in_ready 1 (combinational from count and state), out_valid 0, fence_busy 0. out_* take their empty defaults.
- Latency: push at edge N → out_valid at N+1.
- Throughput: 1 instruction/cycle in steady state with out_ready held high.
- Drain: fence popped at edge N → out_valid=0 and in_ready=0 for exactly FENCE_DRAIN cycles (N+1 … N+FENCE_DRAIN). Normal operation resumes at N+FENCE_DRAIN+1.
- Asynchronous rst mid-drain or mid-transfer: all state clears immediately; buffered entries are lost.

## Configuration
- ID_STAGE_RVM_EN defined:
  - OP with f7=0000001 (MUL/DIV, all eight f3) is legal.
  - An extra output out_is_muldiv (1 bit, 0 when empty) is present.
- Undefined: those encodings assert out_illegal, and out_is_muldiv does not exist.

## Test plan
- Reset then push 0x00500093 @pc 0x100 with out_ready=1:
  - Next cycle: out_valid=1, out_rs1=0, out_rd=1, out_illegal=0.
  - Following cycle: empty.
- out_ready=0 and push 3 instructions with DEPTH=2:
  - in_ready drops after the 2nd push; the 3rd is held by fetch.
  - Release out_ready: in order, no loss, no duplicates.
- Pop fence 0x0FF0000F with FENCE_DRAIN=8:
  - fence_busy=1 and in_ready=0 for exactly 8 cycles.
  - A buffered ADDI appears on cycle 9.
- flush asserted during drain cycle 3 with in_valid=1:
  - Next cycle: count=0, fence_busy=0, in_ready=1.
  - The same-cycle push is dropped.
- Push 0x02208033 (MUL): out_illegal=1 without ID_STAGE_RVM_EN; out_illegal=0 and out_is_muldiv=1 with it.
- Push 0x34202573 (csrrs): out_csr_inst=0x34202573, out_rs2=0.
- Push 0x00000073: out_ecall=1.
- Push 0xFFFFFFFF: out_illegal=1.
